// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and helpers for the CPU trace monitor
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0] CAUSE_HALT    = 2'b10;
  localparam logic [1:0] CAUSE_BOTH    = 2'b11;

  // Trace entry layout is {stamp, pc, ir}
  function automatic int entry_width(input int ts_w, input int pc_w, input int ir_w);
    return ts_w + pc_w + ir_w;
  endfunction

endpackage

// File: rtl/trace_ring_buf.sv
// rtl/trace_ring_buf.sv - circular trace store, overwrites oldest entry when full
module trace_ring_buf #(
  parameter int DEPTH = 16,
  parameter int W     = 80,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic [W-1:0]     head_data,
  output logic [LVL_W-1:0] level,
  output logic             overflow
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             pop;

  // Head view is combinational; an empty buffer shows zero
  always_comb begin
    valid     = (level != '0);
    full      = (level == LVL_W'(DEPTH));
    pop       = valid & pop_ready;
    head_data = valid ? mem[rd_ptr] : '0;
  end

  // Storage array carries no reset; pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer, level and sticky overflow bookkeeping; a push into a full buffer drags rd_ptr along
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop || (push && full)) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop && !full) level <= level + LVL_W'(1);
      else if (!push && pop) level <= level - LVL_W'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu_trace_monitor.sv
// rtl/cpu_trace_monitor.sv - run monitor: cycle budget, self-loop halt detect, PC/IR trace
module cpu_trace_monitor
  import trace_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int IR_W       = 32,
  parameter int TS_W       = 16,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 2048,
  parameter int HALT_LIMIT = 8,
  localparam int ENTRY_W   = entry_width(TS_W, PC_W, IR_W),
  localparam int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               RETIRE,
  input  logic [PC_W-1:0]    PC,
  input  logic [IR_W-1:0]    IR,
  input  logic               RD_READY,
  output logic               RD_VALID,
  output logic [ENTRY_W-1:0] RD_DATA,
  output logic [LVL_W-1:0]   LEVEL,
  output logic               OVERFLOW,
  output logic [CNT_W-1:0]   CYCLES,
  output logic               DONE,
  output logic [1:0]         CAUSE
);

  localparam int RL_W = $clog2(HALT_LIMIT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_AT = (MAX_CYCLES == 0) ? '0 : CNT_W'(MAX_CYCLES - 1);

  state_t          state, next_state;
  logic            in_run;
  logic            start_ok;
  logic            timeout;
  logic            halt;
  logic [RL_W-1:0] run_len, next_run_len;
  logic [PC_W-1:0] last_pc;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Next-state logic; START while running is ignored
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: if (START) next_state = ST_RUN;
      ST_RUN:  if (timeout || halt) next_state = ST_DONE;
      ST_DONE: if (START) next_state = ST_RUN;
      default: next_state = ST_IDLE;
    endcase
  end

  // Decoded state outputs and stop conditions
  always_comb begin
    in_run   = (state == ST_RUN);
    start_ok = START && (state != ST_RUN);
    DONE     = (state == ST_DONE);
    timeout  = in_run && (MAX_CYCLES != 0) && (CYCLES == TIMEOUT_AT);
    if (RETIRE && (run_len != '0) && (PC == last_pc)) next_run_len = run_len + RL_W'(1);
    else                                               next_run_len = RL_W'(1);
    halt = in_run && RETIRE && (next_run_len == RL_W'(HALT_LIMIT));
  end

  // Cycle counter, halt run tracker and stop cause; START clears them for a fresh run
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CYCLES  <= '0;
      CAUSE   <= CAUSE_NONE;
      run_len <= '0;
      last_pc <= '0;
    end else if (start_ok) begin
      CYCLES  <= '0;
      CAUSE   <= CAUSE_NONE;
      run_len <= '0;
      last_pc <= '0;
    end else if (in_run) begin
      if (CYCLES != '1) CYCLES <= CYCLES + CNT_W'(1);
      if (RETIRE) begin
        last_pc <= PC;
        run_len <= next_run_len;
      end
      if (timeout || halt) CAUSE <= {halt, timeout};
    end
  end

  trace_ring_buf #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_ring (
    .clk       (CLK),
    .rst_n     (RST),
    .clear     (start_ok),
    .push      (in_run && RETIRE),
    .push_data ({CYCLES[TS_W-1:0], PC, IR}),
    .pop_ready (RD_READY),
    .valid     (RD_VALID),
    .head_data (RD_DATA),
    .level     (LEVEL),
    .overflow  (OVERFLOW)
  );

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// tb/tb_cpu_trace_monitor.sv - directed bench for cpu_trace_monitor
module tb_cpu_trace_monitor;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        RETIRE;
  logic [31:0] PC;
  logic [31:0] IR;
  logic        RD_READY;
  logic        RD_VALID;
  logic [79:0] RD_DATA;
  logic [4:0]  LEVEL;
  logic        OVERFLOW;
  logic [31:0] CYCLES;
  logic        DONE;
  logic [1:0]  CAUSE;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  cpu_trace_monitor #(
    .PC_W(32), .IR_W(32), .TS_W(16), .DEPTH(16), .CNT_W(32),
    .MAX_CYCLES(2048), .HALT_LIMIT(8)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .RETIRE(RETIRE), .PC(PC), .IR(IR),
    .RD_READY(RD_READY), .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .LEVEL(LEVEL),
    .OVERFLOW(OVERFLOW), .CYCLES(CYCLES), .DONE(DONE), .CAUSE(CAUSE)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  function automatic logic [79:0] ent(input int ts, input int pc, input int ir);
    logic [15:0] t;
    t = ts[15:0];
    return {t, 32'(pc), 32'(ir)};
  endfunction

  // Retire a constant PC until the monitor declares halt (bounded)
  task automatic halt_out(input string tag);
    RETIRE = 1'b1;
    PC     = 32'hFFFF_0000;
    for (int k = 0; k < 20 && !DONE; k++) step();
    RETIRE = 1'b0;
    check({tag, "_done"}, 128'(DONE), 128'(1));
    check({tag, "_cause"}, 128'(CAUSE), 128'(2));
  endtask

  initial begin
    RST = 1'b0; START = 1'b0; RETIRE = 1'b0; PC = '0; IR = '0; RD_READY = 1'b0;
    step(); step();
    check("rst_done", 128'(DONE), 128'(0));
    check("rst_level", 128'(LEVEL), 128'(0));
    check("rst_valid", 128'(RD_VALID), 128'(0));
    check("rst_data", 128'(RD_DATA), 128'(0));
    check("rst_cycles", 128'(CYCLES), 128'(0));
    check("rst_cause", 128'(CAUSE), 128'(0));
    RST = 1'b1;
    step();

    // 1: timeout after exactly 2048 RUN cycles
    do_start();
    check("t1_cyc0", 128'(CYCLES), 128'(0));
    RETIRE = 1'b1;
    for (int c = 0; c < 2048; c++) begin
      PC = 32'(4 * c);
      IR = 32'h2000_0000 | 32'(c);
      step();
      if (c == 2046) check("t1_not_done", 128'(DONE), 128'(0));
    end
    check("t1_done", 128'(DONE), 128'(1));
    check("t1_cause", 128'(CAUSE), 128'(1));
    check("t1_cycles", 128'(CYCLES), 128'(2048));
    check("t1_level", 128'(LEVEL), 128'(16));
    check("t1_ovf", 128'(OVERFLOW), 128'(1));
    check("t1_head", 128'(RD_DATA), 128'(ent(2032, 4 * 2032, 32'h2000_0000 | 2032)));
    PC = 32'h7777_0000;
    step();
    check("t1_no_push_done", 128'(LEVEL), 128'(16));
    check("t1_cycles_hold", 128'(CYCLES), 128'(2048));
    RETIRE = 1'b0;

    // 2: PC stuck at 0x40 from RUN cycle 10 -> halt on the 8th equal retire
    do_start();
    check("t2_cause_clr", 128'(CAUSE), 128'(0));
    check("t2_ovf_clr", 128'(OVERFLOW), 128'(0));
    check("t2_level_clr", 128'(LEVEL), 128'(0));
    RETIRE = 1'b1;
    for (int c = 0; c < 18; c++) begin
      PC = (c < 10) ? 32'(4 * c) : 32'h40;
      IR = 32'(c);
      step();
      if (c == 16) check("t2_not_done", 128'(DONE), 128'(0));
    end
    check("t2_done", 128'(DONE), 128'(1));
    check("t2_cause", 128'(CAUSE), 128'(2));
    check("t2_cycles", 128'(CYCLES), 128'(18));
    RETIRE = 1'b0;

    // 3: 20 pushes into 16 entries, no consumer; head is the 5th push
    do_start();
    RETIRE = 1'b1;
    for (int i = 0; i < 20; i++) begin
      PC = 32'h1000 + 32'(4 * i);
      IR = 32'hA5A5_0000 | 32'(i);
      step();
    end
    RETIRE = 1'b0;
    check("t3_level", 128'(LEVEL), 128'(16));
    check("t3_ovf", 128'(OVERFLOW), 128'(1));
    check("t3_valid", 128'(RD_VALID), 128'(1));
    check("t3_head", 128'(RD_DATA), 128'(ent(4, 32'h1010, 32'hA5A5_0004)));
    RD_READY = 1'b1;
    for (int i = 4; i < 20; i++) begin
      check("t3_drain", 128'(RD_DATA), 128'(ent(i, 32'h1000 + 4 * i, 32'hA5A5_0000 | i)));
      step();
    end
    RD_READY = 1'b0;
    check("t3_empty_level", 128'(LEVEL), 128'(0));
    check("t3_empty_valid", 128'(RD_VALID), 128'(0));
    check("t3_empty_data", 128'(RD_DATA), 128'(0));
    halt_out("t3_halt");

    // 4: full buffer with simultaneous push and pop keeps level and order, no overflow
    do_start();
    RETIRE = 1'b1;
    for (int i = 0; i < 16; i++) begin
      PC = 32'h2000 + 32'(4 * i);
      IR = 32'hC0DE_0000 | 32'(i);
      step();
    end
    check("t4_full", 128'(LEVEL), 128'(16));
    check("t4_ovf0", 128'(OVERFLOW), 128'(0));
    RD_READY = 1'b1;
    for (int i = 16; i < 24; i++) begin
      PC = 32'h2000 + 32'(4 * i);
      IR = 32'hC0DE_0000 | 32'(i);
      check("t4_order", 128'(RD_DATA), 128'(ent(i - 16, 32'h2000 + 4 * (i - 16), 32'hC0DE_0000 | (i - 16))));
      step();
      check("t4_level", 128'(LEVEL), 128'(16));
    end
    RETIRE = 1'b0;
    RD_READY = 1'b0;
    check("t4_ovf_still0", 128'(OVERFLOW), 128'(0));
    check("t4_head", 128'(RD_DATA), 128'(ent(8, 32'h2020, 32'hC0DE_0008)));
    halt_out("t4_halt");

    // 5: halt lands on the last budget cycle -> both causes
    do_start();
    RETIRE = 1'b1;
    for (int c = 0; c < 2048; c++) begin
      PC = (c < 2040) ? 32'h8000 + 32'(4 * c) : 32'h000B_EEF0;
      IR = 32'(c);
      step();
      if (c == 2046) check("t5_not_done", 128'(DONE), 128'(0));
    end
    check("t5_done", 128'(DONE), 128'(1));
    check("t5_cause", 128'(CAUSE), 128'(3));
    check("t5_cycles", 128'(CYCLES), 128'(2048));
    RETIRE = 1'b0;

    // 6: asynchronous reset mid-run, then a clean new run
    do_start();
    RETIRE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      PC = 32'h3000 + 32'(4 * i);
      IR = 32'(i);
      step();
    end
    RETIRE = 1'b0;
    check("t6_level5", 128'(LEVEL), 128'(5));
    #2 RST = 1'b0;
    #1;
    check("t6_rst_level", 128'(LEVEL), 128'(0));
    check("t6_rst_valid", 128'(RD_VALID), 128'(0));
    check("t6_rst_data", 128'(RD_DATA), 128'(0));
    check("t6_rst_cycles", 128'(CYCLES), 128'(0));
    check("t6_rst_done", 128'(DONE), 128'(0));
    check("t6_rst_cause", 128'(CAUSE), 128'(0));
    check("t6_rst_ovf", 128'(OVERFLOW), 128'(0));
    step();
    RST = 1'b1;
    step();
    check("t6_idle_cycles", 128'(CYCLES), 128'(0));
    do_start();
    RETIRE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      PC = 32'h5000 + 32'(4 * i);
      IR = '0;
      step();
    end
    RETIRE = 1'b0;
    check("t6_new_level", 128'(LEVEL), 128'(3));
    check("t6_new_head", 128'(RD_DATA), 128'(ent(0, 32'h5000, 0)));
    check("t6_new_cycles", 128'(CYCLES), 128'(3));
    check("t6_new_done", 128'(DONE), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
